mod_mem: RTL and testbench

Memory-access stage that sits directly downstream of the execution stage. It consumes the ALU result as an effective address and the second source operand as store data. It runs a registered request/acknowledge transaction with a variable-latency data memory and stalls the pipeline until that transaction finishes. It then presents the write-back value, either the loaded word or the ALU result, to the register-file write port.

---
 rtl/mod_mem.sv | 91 +++++++++
 tb/tb_mod_mem.sv | 113 +++++++++++
 2 files changed

// File: rtl/mod_mem.sv
// mod_mem: memory-access stage; registered req/ack transaction with a variable-latency
// data memory, pipeline stall, timeout abort and write-back selection.
module mod_mem #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenable,
    input  logic        memwrite,
    input  logic        memtoreg,
    input  logic [15:0] aluout,
    input  logic [15:0] store_data,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] wb_data,
    output logic        stall,
    output logic        mem_err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_load;
    logic             w_tmo;
    assign w_tmo = (r_state == REQ) && !mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end
    always_comb begin
        w_next  = r_state;
        stall   = 1'b0;
        wb_data = aluout;
        case (r_state)
            IDLE: begin
                stall  = memenable;
                w_next = memenable ? REQ : IDLE;
            end
            REQ: begin
                stall  = 1'b1;
                w_next = (mem_ack || w_tmo) ? DONE : REQ;
            end
            DONE: begin
                wb_data = memtoreg ? r_load : aluout;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r_load    <= '0;
            r_cnt     <= '0;
            mem_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (memenable) begin
                    mem_req   <= 1'b1;
                    mem_we    <= memwrite;
                    mem_addr  <= aluout & 16'hFFFE;
                    mem_wdata <= store_data;
                    r_cnt     <= '0;
                end
                REQ: begin
                    // an ack in the timeout cycle takes priority over the abort
                    if (mem_ack) begin
                        if (!mem_we) r_load <= mem_rdata;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else if (w_tmo) begin
                        mem_err <= 1'b1;
                        r_load  <= '0;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_mem.sv
// tb_mod_mem: directed self-checking bench for mod_mem.
module tb_mod_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memenable = 1'b0, memwrite = 1'b0, memtoreg = 1'b0, mem_ack = 1'b0;
    logic [15:0] aluout = '0, store_data = '0, mem_rdata = '0;
    logic        mem_req, mem_we, stall, mem_err;
    logic [15:0] mem_addr, mem_wdata, wb_data;
    int          checks = 0;
    int          errors = 0;

    mod_mem #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .memenable(memenable), .memwrite(memwrite),
        .memtoreg(memtoreg), .aluout(aluout), .store_data(store_data),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .wb_data(wb_data), .stall(stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one access from IDLE; ack on the n-th REQ cycle (0 = never).
    task automatic access(input logic we, input logic toreg, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [15:0] rd, input int n,
                          input logic [15:0] exp_wb, input int exp_stall,
                          input logic exp_err, input logic keep_en);
        int st = 0;
        int rq = 0;
        logic held = 1'b1;
        memenable = 1'b1; memwrite = we; memtoreg = toreg; aluout = addr;
        store_data = wd; mem_rdata = rd; mem_ack = 1'b0;
        #1;
        while (stall && st < 40) begin
            st++;
            if (mem_req) begin
                rq++;
                held &= (mem_we === we) && (mem_addr === (addr & 16'hFFFE)) && (mem_wdata === wd);
                mem_ack = (rq == n);
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        chk("stall_cycles", 16'(st), 16'(exp_stall));
        chk("req_fields_stable", {15'd0, held}, 16'd1);
        chk("done_req", {15'd0, mem_req}, 16'd0);
        chk("done_wb", wb_data, exp_wb);
        chk("done_err", {15'd0, mem_err}, {15'd0, exp_err});
        memenable = keep_en;
        @(posedge clk); #1;
        chk("idle_req", {15'd0, mem_req}, 16'd0);
    endtask

    initial begin
        memwrite = 1'b1; aluout = 16'hABCD; store_data = 16'h1357;
        mem_ack = 1'b1; mem_rdata = 16'hFFFF; memtoreg = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {15'd0, mem_req}, 16'd0);
        chk("rst_we", {15'd0, mem_we}, 16'd0);
        chk("rst_stall", {15'd0, stall}, 16'd0);
        chk("rst_err", {15'd0, mem_err}, 16'd0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_wdata", mem_wdata, 16'h0000);
        rst = 1'b1; mem_ack = 1'b0;
        memtoreg = 1'b0; aluout = 16'h1234;
        #1;
        chk("pass_stall", {15'd0, stall}, 16'd0);
        chk("pass_wb", wb_data, 16'h1234);
        aluout = 16'hFFFF;
        #1;
        chk("pass_wb_odd", wb_data, 16'hFFFF);
        @(posedge clk); #1;
        chk("pass_req", {15'd0, mem_req}, 16'd0);
        access(1'b0, 1'b1, 16'h0041, 16'h0000, 16'hBEEF, 1, 16'hBEEF, 2, 1'b0, 1'b0);
        access(1'b1, 1'b0, 16'h0100, 16'hA5A5, 16'h0000, 5, 16'h0100, 6, 1'b0, 1'b0);
        access(1'b1, 1'b0, 16'h0333, 16'h5A5A, 16'h0000, 2, 16'h0333, 3, 1'b0, 1'b0);
        access(1'b0, 1'b1, 16'h0200, 16'h0000, 16'h1111, 1, 16'h1111, 2, 1'b0, 1'b1);
        access(1'b0, 1'b1, 16'h0202, 16'h0000, 16'h2222, 3, 16'h2222, 4, 1'b0, 1'b0);
        access(1'b0, 1'b1, 16'h0300, 16'h0000, 16'hC0DE, 16, 16'hC0DE, 17, 1'b0, 1'b0);
        access(1'b0, 1'b1, 16'h0400, 16'h0000, 16'h9999, 0, 16'h0000, 17, 1'b1, 1'b0);
        access(1'b0, 1'b1, 16'h0044, 16'h0000, 16'h7777, 2, 16'h7777, 3, 1'b1, 1'b0);
        memenable = 1'b1; memwrite = 1'b0; memtoreg = 1'b1; aluout = 16'h0050;
        @(posedge clk); #1;
        chk("mid_req_before", {15'd0, mem_req}, 16'd1);
        rst = 1'b0;
        #1;
        chk("mid_req_async", {15'd0, mem_req}, 16'd0);
        chk("mid_err_cleared", {15'd0, mem_err}, 16'd0);
        chk("mid_addr", mem_addr, 16'h0000);
        memenable = 1'b0;
        #1;
        chk("mid_idle_stall", {15'd0, stall}, 16'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req", {15'd0, mem_req}, 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
